// File: rtl/ct_counter_bank_pkg.sv
// Shared encodings for the counter bank: count direction and overflow handling mode.
package ct_counter_bank_pkg;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    function automatic mode_e mode_from_param(input int saturate);
        return (saturate != 0) ? MODE_SAT : MODE_WRAP;
    endfunction

endpackage

// File: rtl/ct_counter_chan.sv
// One up/down counter channel: load > count > hold, with terminal-count pulse and sticky overflow.
module ct_counter_chan
    import ct_counter_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             ovf_o
);

    localparam mode_e            MODE     = mode_from_param(SATURATE);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum_s, diff_s;
    logic             event_s;

    // Next-state: the extra top bit of the WIDTH+1 result is the carry/borrow event flag.
    always_comb begin
        sum_s   = {1'b0, count_q} + STEP_EXT;
        diff_s  = {1'b0, count_q} - STEP_EXT;
        count_d = count_q;
        event_s = 1'b0;
        if (load_i) begin
            count_d = load_val_i;
            event_s = 1'b0;
        end else if (en_i) begin
            if (dir_i == DIR_DN) begin
                event_s = diff_s[WIDTH];
                case (MODE)
                    MODE_SAT: count_d = diff_s[WIDTH] ? MIN_VAL : diff_s[WIDTH-1:0];
                    default:  count_d = diff_s[WIDTH-1:0];
                endcase
            end else begin
                event_s = sum_s[WIDTH];
                case (MODE)
                    MODE_SAT: count_d = sum_s[WIDTH] ? MAX_VAL : sum_s[WIDTH-1:0];
                    default:  count_d = sum_s[WIDTH-1:0];
                endcase
            end
        end else begin
            count_d = count_q;
            event_s = 1'b0;
        end
        tc_d  = event_s;
        ovf_d = event_s | (ovf_q & ~ovf_clr_i);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/ct_counter_bank.sv
// Bank of CHANNELS independent counters; packs/unpacks the flat per-channel buses.
module ct_counter_bank
    import ct_counter_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic                      ovf_clr,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       ovf
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        ct_counter_chan #(
            .WIDTH   (WIDTH),
            .STEP    (STEP),
            .SATURATE(SATURATE)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en[g]),
            .dir_i     (dir[g]),
            .load_i    (load[g]),
            .load_val_i(load_val[g*WIDTH +: WIDTH]),
            .ovf_clr_i (ovf_clr),
            .count_o   (count[g*WIDTH +: WIDTH]),
            .tc_o      (tc[g]),
            .ovf_o     (ovf[g])
        );
    end

endmodule

// File: tb/tb_ct_counter_bank.sv
// Self-checking bench: a wrapping bank (STEP=1) and a saturating bank (STEP=3) driven in parallel.
module tb_ct_counter_bank;

    localparam int W  = 4;
    localparam int CH = 4;
    localparam int BW = W * CH;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en, dir, load;
    logic [BW-1:0] load_val;
    logic          ovf_clr;
    logic [BW-1:0] count_a, count_b;
    logic [CH-1:0] tc_a, tc_b, ovf_a, ovf_b;

    always #5 clk = ~clk;

    ct_counter_bank #(.WIDTH(W), .CHANNELS(CH), .STEP(1), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr), .count(count_a), .tc(tc_a), .ovf(ovf_a)
    );

    ct_counter_bank #(.WIDTH(W), .CHANNELS(CH), .STEP(3), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr), .count(count_b), .tc(tc_b), .ovf(ovf_b)
    );

    typedef struct packed {
        logic [BW-1:0] cnt_a;
        logic [BW-1:0] cnt_b;
        logic [CH-1:0] tc_a;
        logic [CH-1:0] tc_b;
        logic [CH-1:0] ovf_a;
        logic [CH-1:0] ovf_b;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt[2][CH];
    bit   m_tc[2][CH];
    bit   m_ovf[2][CH];

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
                m_cnt[d][c] = 0;
                m_tc[d][c]  = 1'b0;
                m_ovf[d][c] = 1'b0;
            end
    endfunction

    // Reference: instance 0 wraps with step 1, instance 1 clamps with step 3.
    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            int  step = (d == 0) ? 1 : 3;
            bit  sat  = (d == 1);
            for (int c = 0; c < CH; c++) begin
                int s;
                bit ev = 1'b0;
                int nxt = m_cnt[d][c];
                if (load[c]) begin
                    nxt = int'(load_val[c*W +: W]);
                end else if (en[c]) begin
                    if (dir[c] == 1'b0) begin
                        s  = m_cnt[d][c] + step;
                        ev = (s > 15);
                        nxt = ev ? (sat ? 15 : s - 16) : s;
                    end else begin
                        s  = m_cnt[d][c] - step;
                        ev = (s < 0);
                        nxt = ev ? (sat ? 0 : s + 16) : s;
                    end
                end
                m_cnt[d][c] = nxt;
                m_tc[d][c]  = ev;
                m_ovf[d][c] = ev | (m_ovf[d][c] & ~ovf_clr);
            end
        end
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e = '0;
        for (int c = 0; c < CH; c++) begin
            e.cnt_a[c*W +: W] = 4'(m_cnt[0][c]);
            e.cnt_b[c*W +: W] = 4'(m_cnt[1][c]);
            e.tc_a[c]  = m_tc[0][c];
            e.tc_b[c]  = m_tc[1][c];
            e.ovf_a[c] = m_ovf[0][c];
            e.ovf_b[c] = m_ovf[1][c];
        end
        return e;
    endfunction

    task automatic idle();
        en = 4'b0000; dir = 4'b0000; load = 4'b0000; load_val = 16'h0000; ovf_clr = 1'b0;
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        sbq.push_back(snap());
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("count_wrap", count_a, e.cnt_a);
        chk("count_sat",  count_b, e.cnt_b);
        chk("tc_wrap",    {12'h000, tc_a},  {12'h000, e.tc_a});
        chk("tc_sat",     {12'h000, tc_b},  {12'h000, e.tc_b});
        chk("ovf_wrap",   {12'h000, ovf_a}, {12'h000, e.ovf_a});
        chk("ovf_sat",    {12'h000, ovf_b}, {12'h000, e.ovf_b});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count_wrap"}, count_a, 16'h0000);
        chk({tag, "_count_sat"},  count_b, 16'h0000);
        chk({tag, "_tc"},  {8'h00, tc_a, tc_b},   16'h0000);
        chk({tag, "_ovf"}, {8'h00, ovf_a, ovf_b}, 16'h0000);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Count up through the wrap on channel 0.
        en = 4'b0001;
        repeat (15) cycle();
        chk("t1_cnt15", {12'h000, count_a[3:0]}, 16'h000F);
        chk("t1_tc_before_wrap", {15'h0000, tc_a[0]}, 16'h0000);
        cycle();
        chk("t1_cnt_wrap0", {12'h000, count_a[3:0]}, 16'h0000);
        chk("t1_tc_wrap", {15'h0000, tc_a[0]}, 16'h0001);
        chk("t1_ovf_set", {15'h0000, ovf_a[0]}, 16'h0001);
        idle();
        cycle();
        chk("t1_ovf_sticky", {15'h0000, ovf_a[0]}, 16'h0001);
        chk("t1_tc_pulse_end", {15'h0000, tc_a[0]}, 16'h0000);

        // Saturation on channel 0 of the clamping bank.
        load = 4'b0001; load_val = 16'h000D;
        cycle();
        idle(); en = 4'b0001;
        cycle();
        chk("t2_sat_cnt15", {12'h000, count_b[3:0]}, 16'h000F);
        chk("t2_sat_tc", {15'h0000, tc_b[0]}, 16'h0001);
        cycle();
        chk("t2_sat_hold15", {12'h000, count_b[3:0]}, 16'h000F);
        chk("t2_sat_tc_again", {15'h0000, tc_b[0]}, 16'h0001);
        idle(); load = 4'b0001; load_val = 16'h0002;
        cycle();
        idle(); en = 4'b0001; dir = 4'b0001;
        cycle();
        chk("t2_sat_down0", {12'h000, count_b[3:0]}, 16'h0000);
        chk("t2_sat_down_tc", {15'h0000, tc_b[0]}, 16'h0001);
        chk("t2_wrap_down1", {12'h000, count_a[3:0]}, 16'h0001);

        // Load wins over enable and raises no event.
        idle(); load = 4'b0010; en = 4'b0010; load_val = 16'h00F0;
        cycle();
        chk("t3_load_cnt", {12'h000, count_a[7:4]}, 16'h000F);
        chk("t3_load_tc", {15'h0000, tc_a[1]}, 16'h0000);
        chk("t3_load_ovf", {15'h0000, ovf_a[1]}, 16'h0000);

        // Sticky overflow: set beats simultaneous clear; clear alone takes effect.
        idle(); load = 4'b0100; load_val = 16'h0F00;
        cycle();
        idle(); en = 4'b0100;
        cycle();
        idle(); load = 4'b0100; load_val = 16'h0F00;
        cycle();
        idle(); en = 4'b0100; ovf_clr = 1'b1;
        cycle();
        chk("t4_race_ovf", {15'h0000, ovf_a[2]}, 16'h0001);
        idle(); ovf_clr = 1'b1;
        cycle();
        chk("t4_clear_ovf", {12'h000, ovf_a}, 16'h0000);

        // Asynchronous reset between edges.
        idle(); load = 4'b1000; load_val = 16'h9000;
        cycle();
        idle();
        chk("t5_cnt9", {12'h000, count_a[15:12]}, 16'h0009);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("t5_async");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 4'b1000;
        cycle();
        chk("t5_resume_wrap", {12'h000, count_a[15:12]}, 16'h0001);
        chk("t5_resume_sat", {12'h000, count_b[15:12]}, 16'h0003);

        // Random traffic on all channels.
        for (int i = 0; i < 1000; i++) begin
            en       = 4'($urandom);
            dir      = 4'($urandom);
            load     = 4'($urandom) & 4'($urandom);
            load_val = 16'($urandom);
            ovf_clr  = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
